// File: rtl/hist_ram_pkg.sv
// -----------------------------------------------------------------------------
// hist_ram_pkg
//   Shared types and defaults for the pipelined histogram RAM.
//   - hist_state_t : control FSM states (IDLE, DRAIN, CLEAR)
//   - hist_stage_t : one increment-pipeline stage (valid + bin index)
//   - default ADDR_W / CNT_W values used by hist_ram_pipe
//   Stage addresses are stored at HIST_ADDR_W_MAX bits so the struct can be
//   shared by any ADDR_W up to that width; only the low ADDR_W bits are used.
// -----------------------------------------------------------------------------
package hist_ram_pkg;

    localparam int HIST_ADDR_W_DEF = 5;
    localparam int HIST_CNT_W_DEF  = 16;
    localparam int HIST_ADDR_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } hist_state_t;

    typedef struct packed {
        logic                       valid;
        logic [HIST_ADDR_W_MAX-1:0] addr;
    } hist_stage_t;

endpackage

// File: rtl/hist_ram_mem.sv
// -----------------------------------------------------------------------------
// hist_ram_mem
//   Bin storage: register array, one write port and two registered read ports.
//   No reset; contents are defined by the clear engine in hist_ram_pipe.
//   Ports:
//     clk        clock
//     we/waddr/wdata        write port (increment commit or clear)
//     inc_raddr/inc_rdata   increment read port, read-before-write
//     rd_raddr/rd_rdata     readout port, write-through: a write landing in
//                           the same cycle as the read is returned, so the
//                           readout sees every commit up to its read edge
// -----------------------------------------------------------------------------
module hist_ram_mem
    import hist_ram_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W_DEF,
    parameter int CNT_W  = HIST_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CNT_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] inc_raddr,
    output logic [CNT_W-1:0]  inc_rdata,
    input  logic [ADDR_W-1:0] rd_raddr,
    output logic [CNT_W-1:0]  rd_rdata
);

    localparam int NBINS = 1 << ADDR_W;

    logic [CNT_W-1:0] mem_q [NBINS];
    logic [CNT_W-1:0] inc_rdata_q;
    logic [CNT_W-1:0] rd_rdata_q;

    // Array write plus both synchronous read ports.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        inc_rdata_q <= mem_q[inc_raddr];
        if (we && (waddr == rd_raddr)) begin
            rd_rdata_q <= wdata;
        end else begin
            rd_rdata_q <= mem_q[rd_raddr];
        end
    end

    assign inc_rdata = inc_rdata_q;
    assign rd_rdata  = rd_rdata_q;

endmodule

// File: rtl/hist_ram_pipe.sv
// -----------------------------------------------------------------------------
// hist_ram_pipe
//   Pipelined histogram RAM. Every accepted increment adds 1 to bin[inc_addr]
//   by read-modify-write at one request per cycle, with S2->S1 forwarding so
//   back-to-back hits on one bin never stall. Separate readout port and a
//   self-timed clear engine (also run automatically after reset).
//   Pipe: S0 accept -> S1 read bin -> S2 add 1 and write.
//   Optional feature macro: HIST_SAT_EN (bins saturate instead of wrapping).
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     inc_en/inc_addr          increment request, accepted when inc_ready
//     inc_ready                low while draining or clearing
//     rd_en/rd_addr            readout request
//     rd_valid/rd_data         result two cycles after rd_en; rd_data holds
//     clr_start                pulse to clear all bins (ignored while busy)
//     clr_busy                 drain/clear in progress
// -----------------------------------------------------------------------------
module hist_ram_pipe
    import hist_ram_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W_DEF,
    parameter int CNT_W  = HIST_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_addr,
    output logic              inc_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    input  logic              clr_start,
    output logic              clr_busy
);

    hist_state_t      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    hist_stage_t      s1_q, s1_d;
    hist_stage_t      s2_q, s2_d;
    logic             fwd_q, fwd_d;
    logic [CNT_W-1:0] fwd_val_q, fwd_val_d;
    logic             rd_v1_q, rd_v1_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic             we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [CNT_W-1:0] wdata_s;
    logic [CNT_W-1:0] inc_rdata_s;
    logic [CNT_W-1:0] rd_rdata_s;
    logic [CNT_W-1:0] base_s;
    logic [CNT_W-1:0] new_s;

    // Bin update rule: wrap by default, hold at all-ones with HIST_SAT_EN.
    function automatic logic [CNT_W-1:0] bin_inc(input logic [CNT_W-1:0] v);
`ifdef HIST_SAT_EN
        bin_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
`else
        bin_inc = v + CNT_W'(1);
`endif
    endfunction

    hist_ram_mem #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_mem (
        .clk       (clk),
        .we        (we_s),
        .waddr     (waddr_s),
        .wdata     (wdata_s),
        .inc_raddr (s1_q.addr[ADDR_W-1:0]),
        .inc_rdata (inc_rdata_s),
        .rd_raddr  (rd_addr),
        .rd_rdata  (rd_rdata_s)
    );

    // Increment pipeline, forwarding, write-port mux and readout pipeline.
    always_comb begin
        s1_d.valid = inc_en && ready_q;
        s1_d.addr  = HIST_ADDR_W_MAX'(inc_addr);
        s2_d       = s1_q;
        // S1's array read misses S2's same-cycle write; carry S2's result along.
        base_s     = fwd_q ? fwd_val_q : inc_rdata_s;
        new_s      = bin_inc(base_s);
        fwd_d      = s1_q.valid && s2_q.valid && (s1_q.addr == s2_q.addr);
        fwd_val_d  = new_s;
        // The pipeline is always empty in CLEAR, so the two writers never collide.
        if (state_q == CLEAR) begin
            we_s    = 1'b1;
            waddr_s = ptr_q;
            wdata_s = {CNT_W{1'b0}};
        end else begin
            we_s    = s2_q.valid;
            waddr_s = s2_q.addr[ADDR_W-1:0];
            wdata_s = new_s;
        end
        rd_v1_d    = rd_en;
        rd_valid_d = rd_v1_q;
        if (rd_v1_q) begin
            rd_data_d = rd_rdata_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Clear-control FSM next state; DRAIN leaves once S1 is empty because
    // S2's final write lands on the same edge that enters CLEAR.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                ptr_d = {ADDR_W{1'b0}};
                if (!s1_q.valid) begin
                    state_d = CLEAR;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State registers; reset aborts the pipeline and restarts the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            ptr_q      <= {ADDR_W{1'b0}};
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            fwd_q      <= 1'b0;
            fwd_val_q  <= {CNT_W{1'b0}};
            rd_v1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            fwd_q      <= fwd_d;
            fwd_val_q  <= fwd_val_d;
            rd_v1_q    <= rd_v1_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign inc_ready = ready_q;
    assign clr_busy  = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule
